vend_sequencer: RTL and testbench

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_pkg.sv | 14 +
 rtl/vend_timer.sv | 27 ++
 rtl/vend_sequencer.sv | 92 +++++++++
 tb/tb_vend_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, credit width and coin valuation for the vending sequencer
package vend_pkg;

    localparam int CREDIT_W   = 4;
    localparam int CREDIT_MAX = (1 << CREDIT_W) - 1;

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    // Value of a single inserted coin in 5-cent units, one bit wider than credit so sums cannot wrap
    function automatic logic [CREDIT_W:0] coin_value(input logic c5, input logic c10);
        return c10 ? (CREDIT_W+1)'(2) : (CREDIT_W+1)'(c5);
    endfunction

endpackage

// File: rtl/vend_timer.sv
// vend_timer: counts idle cycles while collecting credit and flags the refund deadline
module vend_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    // Idle-cycle counter; clear wins over enable so an accepted coin restarts the window
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;

    assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin-credit vending FSM with dispense and change-return handshakes
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE   = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin5,
    input  logic                coin10,
    input  logic                cancel,
    output logic                disp_req,
    input  logic                disp_ack,
    output logic                chg_req,
    input  logic                chg_ack,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    state_t              state, state_nx;
    logic [CREDIT_W-1:0] credit_nx;
    logic [CREDIT_W:0]   sum;
    logic                open, cancel_ok, coin_acc, reject_nx;
    logic                timer_clr, timer_en, expired;

    assign sum       = {1'b0, credit} + coin_value(coin5, coin10);
    assign open      = (state == IDLE) || (state == CREDIT);
    assign cancel_ok = (state == CREDIT) && cancel;
    assign coin_acc  = open && !cancel_ok && (coin5 ^ coin10) && (sum <= (CREDIT_W+1)'(CREDIT_MAX));
    assign reject_nx = (coin5 | coin10) && !coin_acc;
    assign timer_en  = (state == CREDIT) && !coin_acc;
    assign timer_clr = !timer_en;

    vend_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (expired)
    );

    // Next state and next credit; cancel outranks coins, an accepted coin outranks the timeout
    always_comb begin
        state_nx  = state;
        credit_nx = credit;
        case (state)
            IDLE, CREDIT: begin
                if (cancel_ok)
                    state_nx = CHANGE;
                else if (coin_acc) begin
                    credit_nx = sum[CREDIT_W-1:0];
                    state_nx  = (sum >= (CREDIT_W+1)'(PRICE)) ? VEND : CREDIT;
                end else if (expired)
                    state_nx = CHANGE;
            end
            VEND: begin
                if (disp_ack) begin
                    credit_nx = credit - CREDIT_W'(PRICE);
                    state_nx  = (credit > CREDIT_W'(PRICE)) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (chg_ack) begin
                    credit_nx = credit - 1'b1;
                    state_nx  = (credit == CREDIT_W'(1)) ? IDLE : CHANGE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and all outputs registered together so every output is a clean flop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= IDLE;
            credit      <= '0;
            disp_req    <= 1'b0;
            chg_req     <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            credit      <= credit_nx;
            disp_req    <= state_nx == VEND;
            chg_req     <= state_nx == CHANGE;
            coin_reject <= reject_nx;
            busy        <= (state_nx == VEND) || (state_nx == CHANGE);
        end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: scoreboard bench driving two price variants with shared random stimulus
module tb_vend_sequencer;

    localparam int TO = 16;

    typedef struct packed {
        logic [3:0] credit;
        logic       dreq;
        logic       creq;
        logic       rej;
        logic       busy;
    } obs_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       coin5 = 1'b0, coin10 = 1'b0, cancel = 1'b0, disp_ack = 1'b0, chg_ack = 1'b0;
    logic [1:0] dreq, creq, rej, busy;
    logic [3:0] cr0, cr1;

    int   checks = 0, errors = 0;
    int   price [2] = '{3, 15};
    int   m_cr [2], m_idle [2];
    bit   m_vend [2], m_ref [2];
    obs_t q0 [$], q1 [$];

    vend_sequencer #(.PRICE(3), .TIMEOUT(TO)) dut0 (
        .clk(clk), .rst_n(rst_n), .coin5(coin5), .coin10(coin10), .cancel(cancel),
        .disp_req(dreq[0]), .disp_ack(disp_ack), .chg_req(creq[0]), .chg_ack(chg_ack),
        .coin_reject(rej[0]), .credit(cr0), .busy(busy[0])
    );

    vend_sequencer #(.PRICE(15), .TIMEOUT(TO)) dut1 (
        .clk(clk), .rst_n(rst_n), .coin5(coin5), .coin10(coin10), .cancel(cancel),
        .disp_req(dreq[1]), .disp_ack(disp_ack), .chg_req(creq[1]), .chg_ack(chg_ack),
        .coin_reject(rej[1]), .credit(cr1), .busy(busy[1])
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp(string tag, obs_t e, obs_t a);
        chk({tag, ".credit"}, 8'(a.credit), 8'(e.credit));
        chk({tag, ".disp_req"}, 8'(a.dreq), 8'(e.dreq));
        chk({tag, ".chg_req"}, 8'(a.creq), 8'(e.creq));
        chk({tag, ".coin_reject"}, 8'(a.rej), 8'(e.rej));
        chk({tag, ".busy"}, 8'(a.busy), 8'(e.busy));
    endtask

    // Reference: credit plus two activity flags; collecting means credit held with nothing in progress
    function automatic obs_t model_step(int i, bit c5, bit c10, bit can, bit da, bit ca);
        bit rej = 0;
        bit acc = 0;
        bit had;
        int val = c10 ? 2 : 1;
        if (m_vend[i] || m_ref[i]) begin
            rej = c5 | c10;
            if (m_vend[i] && da) begin
                m_cr[i] -= price[i];
                m_vend[i] = 0;
                m_ref[i] = m_cr[i] > 0;
            end else if (m_ref[i] && ca) begin
                m_cr[i] -= 1;
                m_ref[i] = m_cr[i] > 0;
            end
        end else if (m_cr[i] > 0 && can) begin
            rej = c5 | c10;
            m_ref[i] = 1;
        end else begin
            had = m_cr[i] > 0;
            if (c5 || c10) begin
                if ((c5 && c10) || m_cr[i] + val > 15) rej = 1;
                else begin
                    acc = 1;
                    m_cr[i] += val;
                    m_idle[i] = 0;
                    m_vend[i] = m_cr[i] >= price[i];
                end
            end
            if (had && !acc) begin
                m_idle[i]++;
                if (m_idle[i] == TO) m_ref[i] = 1;
            end
        end
        return '{credit: 4'(m_cr[i]), dreq: m_vend[i], creq: m_ref[i], rej: rej, busy: m_vend[i] || m_ref[i]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cr[i] = 0;
            m_idle[i] = 0;
            m_vend[i] = 0;
            m_ref[i] = 0;
        end
    endfunction

    task automatic step(bit c5, bit c10, bit can, bit da, bit ca);
        @(negedge clk);
        coin5 = c5;
        coin10 = c10;
        cancel = can;
        disp_ack = da;
        chg_ack = ca;
        q0.push_back(model_step(0, c5, c10, can, da, ca));
        q1.push_back(model_step(1, c5, c10, can, da, ca));
    endtask

    // Monitor: after each edge, compare what each DUT presents with the oldest expectation
    initial forever begin
        @(posedge clk);
        #2;
        if (q0.size() > 0) cmp("dut0", q0.pop_front(), {cr0, dreq[0], creq[0], rej[0], busy[0]});
        if (q1.size() > 0) cmp("dut1", q1.pop_front(), {cr1, dreq[1], creq[1], rej[1], busy[1]});
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        cmp("reset0", '0, {cr0, dreq[0], creq[0], rej[0], busy[0]});
        cmp("reset1", '0, {cr1, dreq[1], creq[1], rej[1], busy[1]});
        rst_n = 1'b1;
        // Three nickels reach the price, dispense, no change
        repeat (3) step(1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // Two dimes overpay by one, one coin of change
        repeat (2) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        // Nickel then cancel refunds it
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        // Simultaneous coins rejected; coin during VEND rejected
        step(1, 1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        // Dime then idle until the refund deadline, two coins back
        step(0, 1, 0, 0, 0);
        repeat (TO) step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1);
        // Random traffic with periodic quiet stretches that let the deadline expire
        for (int n = 0; n < 2500; n++) begin
            bit quiet = (n % 200) >= 170;
            step(!quiet && $urandom_range(0, 5) == 0, !quiet && $urandom_range(0, 6) == 0,
                 !quiet && $urandom_range(0, 20) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end
        // Drain both DUTs to idle, then reset asynchronously while dut0 is dispensing
        repeat (40) step(0, 0, 0, 1, 1);
        repeat (2) step(0, 1, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("pre_reset.disp_req", 8'(dreq[0]), 8'd1);
        chk("pre_reset.queue", 8'(q0.size() + q1.size()), 8'd0);
        rst_n = 1'b0;
        #1;
        cmp("async0", '0, {cr0, dreq[0], creq[0], rej[0], busy[0]});
        cmp("async1", '0, {cr1, dreq[1], creq[1], rej[1], busy[1]});
        @(negedge clk);
        coin10 = 1'b0;
        rst_n = 1'b1;
        model_reset();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
